// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with one-shot and periodic modes.
// A three-state control FSM (IDLE/RUN/PAUSED) gates the decrement. A
// one-cycle done pulse marks the terminal count. In periodic mode the count
// reloads from the value captured at the last load.
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  logic             done_reg, done_next;

  // State, count, reload value and done pulse registers; reset is immediate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      reload_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      reload_reg <= reload_next;
      done_reg   <= done_next;
    end
  end

  // Next-state logic. Priority each cycle: load, then pause, then start,
  // then the decrement.
  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    reload_next = reload_reg;
    done_next   = 1'b0;

    if (load) begin
      // A load aborts any count in progress and suppresses the done pulse.
      count_next  = load_value;
      reload_next = load_value;
      state_next  = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          // A zero count has nothing to time, so start is ignored.
          // The count is held in the transition cycle.
          if (start && (count_reg != '0)) begin
            state_next = RUN;
          end
        end

        RUN: begin
          if (pause) begin
            state_next = PAUSED;
          end else if (count_reg > ONE) begin
            count_next = count_reg - ONE;
          end else if (count_reg == ONE) begin
            // Terminal cycle. auto_reload only matters here.
            done_next = 1'b1;
            if (auto_reload) begin
              count_next = reload_reg;
            end else begin
              count_next = '0;
              state_next = IDLE;
            end
          end else begin
            // A zero count in RUN cannot arise; fall back to IDLE if it does.
            state_next = IDLE;
          end
        end

        PAUSED: begin
          // pause wins when pause and start are high together.
          if (!pause && start) begin
            state_next = RUN;
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Outputs come straight from the registers.
  always_comb begin
    count = count_reg;
    busy  = (state_reg != IDLE);
    done  = done_reg;
  end

endmodule
